slowmem_arbiter: RTL and testbench
==================================

// Module: slowmem_arbiter
// PURPOSE
//  Shares the single slowmem port among the four cache requesters (icache0, icache1, dcache0, dcache1).
//  Grants one transaction at a time using round-robin order, and drives strobe/rnotw/addr/wdata to slowmem.
//  For reads, waits for mfc, latches rdata, and acks the owning requester.
//  Also owns the read-timeout/retry policy for the processor's memory path.
// PARAMETERS
//  N_REQ      4    number of requesters; index 0=icache0, 1=icache1, 2=dcache0, 3=dcache1
//  PTRW       2    width of grant index, equal to clog2(N_REQ)
//  AW         16   address width
//  DW         16   data width
//  MEM_DELAY  4    slowmem read delay; bench reference only, no RTL effect
//  TIMEOUT    16   cycles spent in WAIT without mfc before the read is reissued
// PORTS
//  clk          in   1         clock, rising edge
//  reset        in   1         asynchronous, active-high
//  req          in   N_REQ     per-requester request level
//  req_rnotw    in   N_REQ     1=read, 0=write; one bit per requester
//  req_addr     in   N_REQ*AW  flattened; requester i occupies [i*AW +: AW]
//  req_wdata    in   N_REQ*DW  flattened; requester i occupies [i*DW +: DW]
//  ack          out  N_REQ     one-cycle completion pulse to the granted requester
//  rdata        out  DW        read data; valid in the ack cycle; broadcast to all requesters
//  gnt_id       out  PTRW      index of the current or most recent grantee
//  busy         out  1         1 whenever state != IDLE
//  timeout_err  out  1         sticky; set on any timeout; cleared only by reset
//  mem_strobe   out  1         to slowmem
//  mem_rnotw    out  1         to slowmem
//  mem_addr     out  AW        to slowmem
//  mem_wdata    out  DW        to slowmem
//  mem_mfc      in   1         from slowmem; one-cycle pulse
//  mem_rdata    in   DW        from slowmem
// BEHAVIOUR
//  Reset values (asynchronous, forced immediately):
//   - state=IDLE, mem_strobe=0, mem_rnotw=1, mem_addr=0, mem_wdata=0
//   - ack=0, rdata=0, gnt_id=0, busy=0, timeout_err=0
//   - rr_ptr=N_REQ-1, so requester 0 wins first; wait_cnt=0
//  States: IDLE, ISSUE, WAIT, DONE.
//  IDLE:
//   - If req is nonzero, pick the first set bit searching from rr_ptr+1 (mod N_REQ), wrapping around.
//   - Latch gnt_id, rnotw, addr and wdata of the winner; set rr_ptr=winner; go to ISSUE.
//   - Requester inputs changed after the grant are ignored.
//  ISSUE:
//   - mem_strobe=1 for exactly this cycle, with the latched rnotw/addr/wdata.
//   - Read: go to WAIT with wait_cnt=0. Write: go to DONE.
//  WAIT:
//   - mem_strobe=0.
//   - If mem_mfc=1: rdata<=mem_rdata, go to DONE.
//   - Else if wait_cnt==TIMEOUT-1: set timeout_err, go to ISSUE to reissue the same read.
//   - Else wait_cnt++.
//  DONE:
//   - ack[gnt_id]=1 for this one cycle; all other ack bits stay 0; go to IDLE.
//   - req is not sampled in DONE.
//  Latency, counted from the first IDLE cycle that sees req:
//   - Write: ack at cycle +2.
//   - Read: ack at cycle MEM_DELAY+3 (=7 with the default delay).
//  Handshake:
//   - Requester holds req until ack, then drops req on the following edge.
//   - A req still high in IDLE after DONE is treated as a new request.
//  Serialisation: at most one slowmem transaction outstanding; mem_strobe is never high in consecutive cycles.
//  Stale signals:
//   - mem_mfc outside WAIT is ignored: no state change, no rdata update.
//   - This covers a pending slowmem read that was abandoned by reset mid-operation.
//  Other rules:
//   - Requests that are not granted wait; no request is dropped or starved.
//   - Worst-case wait is N_REQ-1 transactions.
//   - wait_cnt is sized to hold TIMEOUT-1; a wrap-around of wait_cnt cannot occur.
// STRUCTURE
//  Shared header sik_mem_defs.vh holds:
//   - `WORD, `MEMDELAY
//   - state encodings (2 bits)
//   - requester index constants (REQ_IC0..REQ_DC1)
//  Sub-module rr_picker: combinational rotate-and-priority-encode.
//   - Inputs: req, rr_ptr. Outputs: any, winner.
//  The arbiter instantiates one rr_picker; the FSM, latches and counters live in slowmem_arbiter.
// TESTING (bench uses the real slowmem, MEM_DELAY=4)
//  1. Single read: req=0001, addr=0x0010, m[0x10]=0xBEEF.
//     -> one strobe with rnotw=1; ack=0001 at +7; rdata=0xBEEF.
//  2. Single write: req=0100, rnotw=0, addr=0x20, wdata=0x1234.
//     -> ack=0100 at +2.
//     -> A following read of 0x20 by requester 0 returns 0x1234.
//  3. All four request reads together, each held until its ack.
//     -> Grant order 0,1,2,3, then 0 again if req 0 is reasserted.
//     -> Exactly one ack per transaction; strobe never high in back-to-back cycles.
//  4. Timeout: bench model holds mfc=0 for 20 cycles.
//     -> Strobe reissued after 16 WAIT cycles; timeout_err=1.
//     -> Ack follows after the real mfc, with the correct rdata.
//  5. Reset asserted during WAIT of a read.
//     -> All outputs reset immediately.
//     -> The later stale mfc produces no ack.
//     -> The next req=0010 is granted (rr_ptr=3, so index 1 is found first).
//  6. Requester 2 re-requests right after its ack while requester 3 is waiting.
//     -> Requester 3 is granted before requester 2 again.

Source files
------------

// File: rtl/slowmem_arbiter_pkg.sv
// Shared constants for the slowmem arbiter: sizes, FSM encodings and requester indices.
package slowmem_arbiter_pkg;

    localparam int N_REQ     = 4;
    localparam int PTRW      = 2;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int MEM_DELAY = 4;
    localparam int TIMEOUT   = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [PTRW-1:0] REQ_IC0 = 2'd0;
    localparam logic [PTRW-1:0] REQ_IC1 = 2'd1;
    localparam logic [PTRW-1:0] REQ_DC0 = 2'd2;
    localparam logic [PTRW-1:0] REQ_DC1 = 2'd3;

endpackage

// File: rtl/slowmem_arbiter_rr_picker.sv
// Round-robin picker: first set request bit strictly after rr_ptr, wrapping around.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTRW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTRW-1:0]  rr_ptr,
    output logic             any,
    output logic [PTRW-1:0]  winner
);

    logic found;
    int   idx;

    // rr_ptr itself is checked last, so the previous winner has the lowest priority.
    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PTRW'(idx);
            end
        end
    end

endmodule

// File: rtl/slowmem_arbiter.sv
// Shares the slowmem port among four cache requesters, one transaction at a time,
// with round-robin grant and a read timeout that reissues the stalled read.
module slowmem_arbiter
    import slowmem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_rnotw,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic [PTRW-1:0]     gnt_id,
    output logic                busy,
    output logic                timeout_err,
    output logic                mem_strobe,
    output logic                mem_rnotw,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic                mem_mfc,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int CNTW = $clog2(TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0] gnt_id_q, gnt_id_d;
    logic            rnotw_q, rnotw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    logic            pick_any;
    logic [PTRW-1:0] pick_winner;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTRW  (PTRW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_id_d      = gnt_id_q;
        rnotw_d       = rnotw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_id_d = pick_winner;
                    rnotw_d  = req_rnotw[pick_winner];
                    addr_d   = req_addr[int'(pick_winner)*AW +: AW];
                    wdata_d  = req_wdata[int'(pick_winner)*DW +: DW];
                    rr_ptr_d = pick_winner;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rnotw_q) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                // A timed-out read goes back through ISSUE with the same latched request.
                if (mem_mfc) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (wait_cnt_q == CNTW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_ISSUE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= PTRW'(N_REQ - 1);
            gnt_id_q      <= '0;
            rnotw_q       <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_id_q      <= gnt_id_d;
            rnotw_q       <= rnotw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_strobe  = (state_q == ST_ISSUE);
    assign mem_rnotw   = rnotw_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign ack         = (state_q == ST_DONE) ? (N_REQ'(1) << gnt_id_q) : '0;
    assign rdata       = rdata_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_slowmem_arbiter.sv
// Directed bench for slowmem_arbiter with a behavioural slowmem (read delay MEM_DELAY).
module tb_slowmem_arbiter;
    import slowmem_arbiter_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ-1:0]    req_rnotw = '0;
    logic [N_REQ*AW-1:0] req_addr = '0;
    logic [N_REQ*DW-1:0] req_wdata = '0;
    logic [N_REQ-1:0]    ack;
    logic [DW-1:0]       rdata;
    logic [PTRW-1:0]     gnt_id;
    logic                busy;
    logic                timeout_err;
    logic                mem_strobe;
    logic                mem_rnotw;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_mfc = 1'b0;
    logic [DW-1:0]       mem_rdata = '0;

    int compared = 0;
    int mismatched = 0;

    slowmem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_rnotw   (req_rnotw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ack         (ack),
        .rdata       (rdata),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .mem_strobe  (mem_strobe),
        .mem_rnotw   (mem_rnotw),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mfc     (mem_mfc),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural slowmem plus bus monitor. Default contents are {8'hA5, addr[7:0]};
    // the first drop_count read strobes are swallowed to provoke a timeout.
    logic [DW-1:0] mem [0:255];
    logic          loaded = 1'b0;
    logic          pend = 1'b0;
    int            pcnt = 0;
    logic [7:0]    paddr = '0;
    int            drop_count = 0;
    int            dropped = 0;
    int            strobe_cnt = 0;
    int            ack_cnt = 0;
    logic          prev_strobe = 1'b0;
    logic          b2b_seen = 1'b0;
    logic          multi_ack = 1'b0;
    logic          last_rnotw = 1'b0;
    logic [AW-1:0] last_addr = '0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
            mem[8'h10] = 16'hBEEF;
            mem[8'h30] = 16'hCAFE;
            loaded = 1'b1;
        end
        mem_mfc <= 1'b0;
        if (pend) begin
            if (pcnt == 1) begin
                mem_mfc   <= 1'b1;
                mem_rdata <= mem[paddr];
                pend = 1'b0;
            end else begin
                pcnt--;
            end
        end
        if (mem_strobe === 1'b1) begin
            strobe_cnt++;
            last_rnotw = mem_rnotw;
            last_addr  = mem_addr;
            if (prev_strobe) b2b_seen = 1'b1;
            if (mem_rnotw) begin
                if (dropped < drop_count) begin
                    dropped++;
                end else begin
                    pend  = 1'b1;
                    pcnt  = MEM_DELAY;
                    paddr = mem_addr[7:0];
                end
            end else begin
                mem[mem_addr[7:0]] = mem_wdata;
            end
        end
        prev_strobe = (mem_strobe === 1'b1);
        if (ack !== '0) ack_cnt++;
        if ($countones(ack) > 1) multi_ack = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic rnotw, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        req_rnotw[idx]         = rnotw;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wdata;
        req[idx]               = 1'b1;
    endtask

    // Returns the cycle offset of the ack relative to the current (IDLE) cycle.
    task automatic waitAck(output int n);
        n = 0;
        while (ack === '0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) checkOutput("ack_wait_expired", 32'(n), 32'd0);
    endtask

    // Drop req in the ack cycle and step into the following IDLE cycle.
    task automatic finishTxn(input int idx);
        req[idx] = 1'b0;
        tick();
    endtask

    int n;
    int s0;
    int a0;
    logic ack_seen;
    logic busy_seen;

    initial begin
        $display("[TB] start");
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_gnt", 32'(gnt_id), 32'h0);
        checkOutput("rst_strobe", 32'(mem_strobe), 32'h0);
        checkOutput("rst_rnotw", 32'(mem_rnotw), 32'h1);
        checkOutput("rst_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_terr", 32'(timeout_err), 32'h0);

        // 1. single read by requester 0
        s0 = strobe_cnt;
        applyStimulus(REQ_IC0, 1'b1, 16'h0010, 16'h0);
        waitAck(n);
        checkOutput("rd1_lat", 32'(n), 32'd7);
        checkOutput("rd1_ack", 32'(ack), 32'h1);
        checkOutput("rd1_rdata", 32'(rdata), 32'hBEEF);
        finishTxn(0);
        checkOutput("rd1_strobes", 32'(strobe_cnt - s0), 32'd1);
        checkOutput("rd1_rnotw", 32'(last_rnotw), 32'h1);
        checkOutput("rd1_addr", 32'(last_addr), 32'h0010);
        checkOutput("rd1_idle", 32'(busy), 32'h0);

        // 2. single write by requester 2, then read it back through requester 0
        applyStimulus(REQ_DC0, 1'b0, 16'h0020, 16'h1234);
        waitAck(n);
        checkOutput("wr2_lat", 32'(n), 32'd2);
        checkOutput("wr2_ack", 32'(ack), 32'h4);
        finishTxn(2);
        applyStimulus(REQ_IC0, 1'b1, 16'h0020, 16'h0);
        waitAck(n);
        checkOutput("wr2_rb_gnt", 32'(gnt_id), 32'd0);
        checkOutput("wr2_rb_data", 32'(rdata), 32'h1234);
        finishTxn(0);

        // requester 3 write leaves rr_ptr at 3 for the fairness test
        applyStimulus(REQ_DC1, 1'b0, 16'h0050, 16'h5555);
        waitAck(n);
        checkOutput("wr3_ack", 32'(ack), 32'h8);
        finishTxn(3);

        // 3. all four read together
        s0 = strobe_cnt;
        a0 = ack_cnt;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 16'(16'h0040 + i), 16'h0);
        for (int i = 0; i < 4; i++) begin
            waitAck(n);
            checkOutput($sformatf("rr_gnt%0d", i), 32'(gnt_id), 32'(i));
            checkOutput($sformatf("rr_ack%0d", i), 32'(ack), 32'(1 << i));
            checkOutput($sformatf("rr_data%0d", i), 32'(rdata), 32'(16'hA540 + i));
            checkOutput($sformatf("rr_lat%0d", i), 32'(n), 32'd7);
            req[i] = 1'b0;
            if (i == 3) applyStimulus(REQ_IC0, 1'b1, 16'h0010, 16'h0);
            tick();
        end
        waitAck(n);
        checkOutput("rr_again_gnt", 32'(gnt_id), 32'd0);
        checkOutput("rr_again_data", 32'(rdata), 32'hBEEF);
        finishTxn(0);
        checkOutput("rr_strobes", 32'(strobe_cnt - s0), 32'd5);
        checkOutput("rr_acks", 32'(ack_cnt - a0), 32'd5);
        checkOutput("rr_b2b", 32'(b2b_seen), 32'h0);
        checkOutput("rr_multi_ack", 32'(multi_ack), 32'h0);

        // 4. timeout: first read strobe gets no response, reissue after 16 WAIT cycles
        s0 = strobe_cnt;
        drop_count = dropped + 1;
        applyStimulus(REQ_IC0, 1'b1, 16'h0030, 16'h0);
        waitAck(n);
        checkOutput("to_lat", 32'(n), 32'd24);
        checkOutput("to_err", 32'(timeout_err), 32'h1);
        checkOutput("to_data", 32'(rdata), 32'hCAFE);
        finishTxn(0);
        checkOutput("to_strobes", 32'(strobe_cnt - s0), 32'd2);
        checkOutput("to_b2b", 32'(b2b_seen), 32'h0);

        // 5. reset during WAIT; the late mfc must be ignored
        applyStimulus(REQ_DC1, 1'b1, 16'h0010, 16'h0);
        tick();
        tick();
        tick();
        checkOutput("rs_busy_pre", 32'(busy), 32'h1);
        checkOutput("rs_gnt_pre", 32'(gnt_id), 32'd3);
        reset = 1'b1;
        req = '0;
        #1;
        checkOutput("rs_busy", 32'(busy), 32'h0);
        checkOutput("rs_gnt", 32'(gnt_id), 32'h0);
        checkOutput("rs_strobe", 32'(mem_strobe), 32'h0);
        checkOutput("rs_addr", 32'(mem_addr), 32'h0);
        checkOutput("rs_rnotw", 32'(mem_rnotw), 32'h1);
        checkOutput("rs_rdata", 32'(rdata), 32'h0);
        checkOutput("rs_terr", 32'(timeout_err), 32'h0);
        checkOutput("rs_ack", 32'(ack), 32'h0);
        tick();
        reset = 1'b0;
        ack_seen = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ack_seen  = ack_seen | (ack !== '0);
            busy_seen = busy_seen | busy;
        end
        checkOutput("rs_stale_ack", 32'(ack_seen), 32'h0);
        checkOutput("rs_stale_busy", 32'(busy_seen), 32'h0);
        checkOutput("rs_stale_rdata", 32'(rdata), 32'h0);
        applyStimulus(REQ_IC1, 1'b1, 16'h0020, 16'h0);
        waitAck(n);
        checkOutput("rs_next_gnt", 32'(gnt_id), 32'd1);
        checkOutput("rs_next_lat", 32'(n), 32'd7);
        checkOutput("rs_next_data", 32'(rdata), 32'h1234);
        finishTxn(1);

        // 6. requester 2 re-requests right after its ack while 3 waits
        applyStimulus(REQ_DC0, 1'b0, 16'h0060, 16'h6666);
        applyStimulus(REQ_DC1, 1'b0, 16'h0061, 16'h7777);
        waitAck(n);
        checkOutput("fair_first", 32'(gnt_id), 32'd2);
        checkOutput("fair_first_lat", 32'(n), 32'd2);
        req[2] = 1'b0;
        tick();
        applyStimulus(REQ_DC0, 1'b0, 16'h0062, 16'h8888);
        waitAck(n);
        checkOutput("fair_second", 32'(gnt_id), 32'd3);
        checkOutput("fair_second_ack", 32'(ack), 32'h8);
        finishTxn(3);
        waitAck(n);
        checkOutput("fair_third", 32'(gnt_id), 32'd2);
        finishTxn(2);
        applyStimulus(REQ_IC0, 1'b1, 16'h0061, 16'h0);
        waitAck(n);
        checkOutput("fair_rb61", 32'(rdata), 32'h7777);
        finishTxn(0);
        applyStimulus(REQ_IC0, 1'b1, 16'h0062, 16'h0);
        waitAck(n);
        checkOutput("fair_rb62", 32'(rdata), 32'h8888);
        finishTxn(0);
        checkOutput("end_b2b", 32'(b2b_seen), 32'h0);
        checkOutput("end_multi_ack", 32'(multi_ack), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
